cache_fill_ctrl: RTL and testbench

- Miss-fill controller for the direct-mapped cache data array.
- On a miss it requests the line from memory and accepts the returned bytes.
- For each byte it drives the write-enable, line-select one-hot and byte-select one-hot that gate the 8-bit line registers, then commits the tag.
- Sits between the hit/miss compare logic and the data/tag register array.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_fill_ctrl_onehot_decoder.sv | 18 +
 rtl/cache_fill_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller: address geometry,
// fill FSM state encoding and address field helpers.
package cache_pkg;

    localparam int LINE_IDX_W = 3;
    localparam int BYTE_IDX_W = 2;
    localparam int TAG_W      = 3;
    localparam int ADDR_W     = TAG_W + LINE_IDX_W + BYTE_IDX_W;
    localparam int N_LINES    = 1 << LINE_IDX_W;
    localparam int N_BYTES    = 1 << BYTE_IDX_W;

    // Clears the byte-offset field, leaving {tag,line,0}
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-BYTE_IDX_W){1'b1}}, {BYTE_IDX_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } fill_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [LINE_IDX_W-1:0] addr_line(input logic [ADDR_W-1:0] a);
        return a[BYTE_IDX_W +: LINE_IDX_W];
    endfunction

    function automatic logic [BYTE_IDX_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[BYTE_IDX_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & LINE_MASK;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_onehot_decoder.sv
// Binary-to-one-hot decoder; output is all zeros while en is low.
module onehot_decoder #(
    parameter int IN_W = 2
) (
    input  logic                   en,
    input  logic [IN_W-1:0]        sel,
    output logic [(1<<IN_W)-1:0]   dec
);

    // One comparator per output bit
    generate
        for (genvar gi = 0; gi < (1 << IN_W); gi++) begin : g_dec
            localparam logic [IN_W-1:0] IDX = IN_W'(gi);
            assign dec[gi] = en && (sel == IDX);
        end
    endgenerate

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller for the direct-mapped cache data array.
// Requests a missing line from memory, steers each returned byte into the
// line registers (write enable + line/byte one-hot selects), then commits
// the tag. Optional macro CACHE_FILL_CRIT_FIRST_EN enables critical-byte-first
// fills: memory is given the full miss address and returns the missing byte
// first, with the byte counter wrapping around the line.
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [ADDR_W-1:0]     miss_addr,
    output logic                  busy,
    output logic                  fill_done,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [7:0]            mem_rdata,
    output logic                  reg_write,
    output logic [N_LINES-1:0]    line_dec,
    output logic [N_BYTES-1:0]    byte_dec,
    output logic [7:0]            wr_data,
    output logic                  tag_write,
    output logic [TAG_W-1:0]      tag_data,
    output logic                  crit_valid
);

    localparam logic [BYTE_IDX_W-1:0] LAST_BEAT = '1;
    localparam logic [BYTE_IDX_W-1:0] ONE_BEAT  = BYTE_IDX_W'(1);

    // FSM and captured-miss state
    fill_state_t             state_q, state_d;
    logic [BYTE_IDX_W-1:0]   cnt_q, cnt_d;       // byte offset of the next beat
    logic [BYTE_IDX_W-1:0]   beats_q, beats_d;   // beats received in this fill
    logic [BYTE_IDX_W-1:0]   start_q, start_d;   // offset the first beat lands on
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [LINE_IDX_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    beat_fire;

    // Registered outputs
    logic                    busy_q, busy_d;
    logic                    fill_done_q, fill_done_d;
    logic                    mem_req_q, mem_req_d;
    logic                    reg_write_q, reg_write_d;
    logic [N_LINES-1:0]      line_dec_q, line_dec_d;
    logic [N_BYTES-1:0]      byte_dec_q, byte_dec_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    tag_write_q, tag_write_d;
    logic [TAG_W-1:0]        tag_data_q, tag_data_d;

    // State register: FSM state, counters and the captured miss
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beats_q    <= '0;
            start_q    <= '0;
            tag_q      <= '0;
            line_q     <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beats_q    <= beats_d;
            start_q    <= start_d;
            tag_q      <= tag_d;
            line_q     <= line_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Next-state: capture the miss in IDLE, wait for ack, count beats, commit
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beats_d    = beats_q;
        start_d    = start_q;
        tag_d      = tag_q;
        line_d     = line_q;
        mem_addr_d = mem_addr_q;
        beat_fire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    state_d = REQ;
                    tag_d   = addr_tag(miss_addr);
                    line_d  = addr_line(miss_addr);
`ifdef CACHE_FILL_CRIT_FIRST_EN
                    mem_addr_d = miss_addr;
                    start_d    = addr_off(miss_addr);
`else
                    mem_addr_d = line_base(miss_addr);
                    start_d    = '0;
`endif
                end
            end
            REQ: begin
                // A beat arriving together with the ack is deliberately dropped
                if (mem_ack) begin
                    state_d = FILL;
                    cnt_d   = start_q;
                    beats_d = '0;
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    beat_fire = 1'b1;
                    cnt_d     = cnt_q + ONE_BEAT;
                    beats_d   = beats_q + ONE_BEAT;
                    if (beats_q == LAST_BEAT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-hot selects for the byte being written this beat
    onehot_decoder #(.IN_W(LINE_IDX_W)) u_line_dec (
        .en  (beat_fire),
        .sel (line_q),
        .dec (line_dec_d)
    );

    onehot_decoder #(.IN_W(BYTE_IDX_W)) u_byte_dec (
        .en  (beat_fire),
        .sel (cnt_q),
        .dec (byte_dec_d)
    );

    // Output decode from the next state so every output is a flop
    always_comb begin
        busy_d      = (state_d != IDLE);
        mem_req_d   = (state_d == REQ);
        reg_write_d = beat_fire;
        wr_data_d   = beat_fire ? mem_rdata : 8'h00;
        tag_write_d = (state_d == COMMIT);
        fill_done_d = (state_d == COMMIT);
        tag_data_d  = (state_d == COMMIT) ? tag_q : '0;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
            mem_req_q   <= 1'b0;
            reg_write_q <= 1'b0;
            line_dec_q  <= '0;
            byte_dec_q  <= '0;
            wr_data_q   <= '0;
            tag_write_q <= 1'b0;
            tag_data_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
            mem_req_q   <= mem_req_d;
            reg_write_q <= reg_write_d;
            line_dec_q  <= line_dec_d;
            byte_dec_q  <= byte_dec_d;
            wr_data_q   <= wr_data_d;
            tag_write_q <= tag_write_d;
            tag_data_q  <= tag_data_d;
        end
    end

`ifdef CACHE_FILL_CRIT_FIRST_EN
    logic crit_valid_q, crit_valid_d;

    // The first beat of every fill carries the critical byte
    always_comb begin
        crit_valid_d = beat_fire && (beats_q == '0);
    end

    // Critical-byte pulse register
    always_ff @(posedge clk) begin
        if (reset) begin
            crit_valid_q <= 1'b0;
        end else begin
            crit_valid_q <= crit_valid_d;
        end
    end

    assign crit_valid = crit_valid_q;
`else
    assign crit_valid = 1'b0;
`endif

    assign busy      = busy_q;
    assign fill_done = fill_done_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign reg_write = reg_write_q;
    assign line_dec  = line_dec_q;
    assign byte_dec  = byte_dec_q;
    assign wr_data   = wr_data_q;
    assign tag_write = tag_write_q;
    assign tag_data  = tag_data_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: table of fill scenarios plus a
// hand-written reset-mid-fill sequence; expected writes are queued as beats
// are driven and compared when the DUT issues reg_write.
module tb_cache_fill_ctrl;

`ifdef CACHE_FILL_CRIT_FIRST_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       miss_valid;
    logic [7:0] miss_addr;
    logic       busy, fill_done, mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack, mem_rvalid;
    logic [7:0] mem_rdata;
    logic       reg_write;
    logic [7:0] line_dec;
    logic [3:0] byte_dec;
    logic [7:0] wr_data;
    logic       tag_write;
    logic [2:0] tag_data;
    logic       crit_valid;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .busy       (busy),
        .fill_done  (fill_done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .reg_write  (reg_write),
        .line_dec   (line_dec),
        .byte_dec   (byte_dec),
        .wr_data    (wr_data),
        .tag_write  (tag_write),
        .tag_data   (tag_data),
        .crit_valid (crit_valid)
    );

    typedef struct {
        logic [7:0]      addr;
        logic [0:3][7:0] b;
        int              gap;
        bit              rv_ack;
        bit              miss_in_fill;
    } vec_t;

    typedef struct {
        logic [7:0] line_dec;
        logic [3:0] byte_dec;
        logic [7:0] data;
        bit         last;
        bit         crit;
        logic [2:0] tag;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         n_done = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_addr = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, 64'({busy, fill_done, mem_req, reg_write, tag_write, crit_valid}), 64'(0));
        check({name, "_dat"}, 64'({mem_addr, line_dec, byte_dec, wr_data, tag_data}), 64'(0));
    endtask

    // Write monitor: pops expected writes, checks quiet outputs otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (busy) check("mem_addr_stable", 64'(mem_addr), 64'(exp_addr));
            if (fill_done) n_done++;
            if (reg_write) begin
                check("write_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("line_dec", 64'(line_dec), 64'(e.line_dec));
                    check("byte_dec", 64'(byte_dec), 64'(e.byte_dec));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    check("commit_flags", 64'({tag_write, fill_done}), 64'({e.last, e.last}));
                    check("crit_valid", 64'(crit_valid), 64'(e.crit));
                    if (e.last) check("tag_data", 64'(tag_data), 64'(e.tag));
                    $display("write line_dec=%02h byte_dec=%01h data=%02h last=%0d", line_dec, byte_dec, wr_data, e.last);
                end
            end else begin
                check("no_write_outs", 64'({tag_write, fill_done, crit_valid, line_dec, byte_dec}), 64'(0));
            end
        end
    end

    task automatic push_beat(input logic [7:0] addr, input int i, input logic [7:0] data);
        exp_t       e;
        logic [1:0] off;
        off        = (CRIT ? addr[1:0] : 2'd0) + 2'(i);
        e.line_dec = 8'd1 << addr[4:2];
        e.byte_dec = 4'd1 << off;
        e.data     = data;
        e.last     = (i == 3);
        e.crit     = CRIT && (i == 0);
        e.tag      = addr[7:5];
        exp_q.push_back(e);
    endtask

    // Issue a miss and hold REQ for two cycles before acking
    task automatic start_miss(input logic [7:0] addr, input bit rv_ack);
        exp_addr   = CRIT ? addr : (addr & 8'hFC);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        miss_valid = 1'b0;
        miss_addr  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("req_held", 64'({busy, mem_req}), 64'(2'b11));
            check("req_addr", 64'(mem_addr), 64'(exp_addr));
            tick();
        end
        mem_ack = 1'b1;
        if (rv_ack) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'hEE;
        end
        tick();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        @(negedge clk);
        check("req_dropped", 64'({busy, mem_req}), 64'(2'b10));
    endtask

    task automatic do_fill(input vec_t v);
        int done0;
        done0 = n_done;
        $display("fill addr=%02h gap=%0d rv_ack=%0d miss_in_fill=%0d", v.addr, v.gap, v.rv_ack, v.miss_in_fill);
        start_miss(v.addr, v.rv_ack);
        if (v.miss_in_fill) begin
            miss_valid = 1'b1;
            miss_addr  = 8'h10;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                miss_valid = 1'b0;
                miss_addr  = 8'h00;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.b[i];
            push_beat(v.addr, i, v.b[i]);
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
            if (i < 3) repeat (v.gap) tick();
        end
        tick();
        @(negedge clk);
        check("idle_after_fill", 64'({busy, mem_req}), 64'(0));
        check("fill_done_count", 64'(n_done - done0), 64'(1));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        repeat (2) tick();
        check("no_refill", 64'(busy), 64'(0));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hAE, {8'h11, 8'h22, 8'h33, 8'h44}, 0, 1'b0, 1'b0};
        vecs[1] = '{8'hAE, {8'h55, 8'h66, 8'h77, 8'h88}, 3, 1'b0, 1'b0};
        vecs[2] = '{8'h5B, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1, 1'b0, 1'b1};
        vecs[3] = '{8'h27, {8'h01, 8'h02, 8'h03, 8'h04}, 0, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, {8'hF0, 8'h0F, 8'h5A, 8'hA5}, 2, 1'b0, 1'b0};

        reset      = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = 8'h00;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        foreach (vecs[k]) do_fill(vecs[k]);

        // Reset after two beats, then a clean fill
        begin
            int done0;
            done0 = n_done;
            $display("fill addr=6D reset after 2 beats");
            start_miss(8'h6D, 1'b0);
            for (int i = 0; i < 2; i++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 8'hC0 + 8'(i);
                push_beat(8'h6D, i, 8'hC0 + 8'(i));
                tick();
                mem_rvalid = 1'b0;
                mem_rdata  = 8'h00;
            end
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clk);
            check_zero("reset_mid_fill");
            check("no_done_after_reset", 64'(n_done - done0), 64'(0));
            check("queue_after_reset", 64'(exp_q.size()), 64'(0));
            tick();
            do_fill(vecs[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
